// File: rtl/shift_seq_pkg.sv
// Shared types and default sizes for the multi-pass shift sequencer.
package shift_seq_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_AMT_W  = 8;
    localparam int DEF_STEP_W = 5;
    localparam int MAX_STEP   = (1 << DEF_STEP_W) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_pass_sequencer_if.sv
// Request, shifter and result signals of the shift sequencer.
// Handshake: a transfer happens at a rising edge where valid && ready; a source holds
// valid and its payload stable until that edge, and ready may depend combinationally on the sink.
interface shift_pass_sequencer_if
    import shift_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int AMT_W  = DEF_AMT_W,
    parameter int STEP_W = DEF_STEP_W
);
    logic              InValid;
    logic              InReady;
    logic [WIDTH-1:0]  InData;
    logic [AMT_W-1:0]  InAmount;
    logic              InShiftIn;
    logic [WIDTH-1:0]  ShfIn;
    logic [STEP_W-1:0] ShfAmount;
    logic              ShfShiftIn;
    logic [WIDTH-1:0]  ShfOut;
    logic              OutValid;
    logic              OutReady;
    logic [WIDTH-1:0]  OutData;
    logic [3:0]        PassCount;

    modport master (
        output InValid, InData, InAmount, InShiftIn, ShfOut, OutReady,
        input  InReady, ShfIn, ShfAmount, ShfShiftIn, OutValid, OutData, PassCount
    );

    modport slave (
        input  InValid, InData, InAmount, InShiftIn, ShfOut, OutReady,
        output InReady, ShfIn, ShfAmount, ShfShiftIn, OutValid, OutData, PassCount
    );
endinterface

// File: rtl/shift_step_calc.sv
// Per-pass step: min(remaining, 2**STEP_W-1), plus the remaining amount after that pass.
module shift_step_calc #(
    parameter int AMT_W  = 8,
    parameter int STEP_W = 5
) (
    input  logic [AMT_W-1:0]  remaining,
    output logic [STEP_W-1:0] step,
    output logic [AMT_W-1:0]  next_remaining
);
    localparam logic [AMT_W-1:0] MaxStepWide = AMT_W'((1 << STEP_W) - 1);

    logic [AMT_W-1:0] step_wide;

    // Compare at full amount width so amounts above the step limit clamp correctly.
    always_comb begin
        step_wide      = (remaining > MaxStepWide) ? MaxStepWide : remaining;
        step           = step_wide[STEP_W-1:0];
        next_remaining = remaining - step_wide;
    end
endmodule

// File: rtl/shift_pass_sequencer.sv
// Splits a large left shift into passes through an external single-cycle barrel shifter,
// feeding each pass result back, and holds the final word until taken downstream.
module shift_pass_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int AMT_W  = DEF_AMT_W,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic                   Clk,
    input  logic                   ResetN,
    shift_pass_sequencer_if.slave  bus,
    output state_e                 dbg_state
);
    state_e            state_q, state_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [AMT_W-1:0]  rem_q, rem_d;
    logic              fill_q, fill_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic [3:0]        pass_q, pass_d;

    logic [STEP_W-1:0] step;
    logic [AMT_W-1:0]  next_rem;
    logic              in_ready;
    logic              accept;

    shift_step_calc #(
        .AMT_W  (AMT_W),
        .STEP_W (STEP_W)
    ) u_step (
        .remaining      (rem_q),
        .step           (step),
        .next_remaining (next_rem)
    );

    // DONE forwards downstream ready upstream so a take and a new accept share one edge.
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.OutReady);
    assign accept   = bus.InValid && in_ready;

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        rem_d       = rem_q;
        fill_d      = fill_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        pass_d      = pass_q;

        case (state_q)
            IDLE: ;
            SHIFT: begin
                work_d = bus.ShfOut;
                rem_d  = next_rem;
                pass_d = (pass_q == 4'hF) ? pass_q : pass_q + 4'd1;
                if (next_rem == '0) begin
                    state_d     = DONE;
                    out_d       = bus.ShfOut;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.OutReady) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = SHIFT;
            work_d  = bus.InData;
            rem_d   = bus.InAmount;
            fill_d  = bus.InShiftIn;
            pass_d  = '0;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= IDLE;
            work_q      <= '0;
            rem_q       <= '0;
            fill_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            pass_q      <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            fill_q      <= fill_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            pass_q      <= pass_d;
        end
    end

    assign bus.InReady    = in_ready;
    assign bus.ShfIn      = work_q;
    assign bus.ShfAmount  = step;
    assign bus.ShfShiftIn = fill_q;
    assign bus.OutValid   = out_valid_q;
    assign bus.OutData    = out_q;
    assign bus.PassCount  = pass_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_shift_pass_sequencer.sv
// Directed bench for shift_pass_sequencer with a behavioural 32-bit barrel shifter attached.
module tb_shift_pass_sequencer;
    import shift_seq_pkg::*;

    logic   Clk;
    logic   ResetN;
    state_e dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    shift_pass_sequencer_if #(.WIDTH(32), .AMT_W(8), .STEP_W(5)) bus ();

    shift_pass_sequencer #(.WIDTH(32), .AMT_W(8), .STEP_W(5)) dut (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    function automatic logic [31:0] barrel(input logic [31:0] d, input logic [4:0] a, input logic f);
        logic [31:0] ones;
        logic [31:0] fill_mask;
        ones      = 32'hFFFF_FFFF;
        fill_mask = f ? ~(ones << a) : 32'h0;
        return (d << a) | fill_mask;
    endfunction

    assign bus.ShfOut = barrel(bus.ShfIn, bus.ShfAmount, bus.ShfShiftIn);

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test to finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] data;
        logic [7:0]  amt;
        logic        fill;
        logic [31:0] exp_data;
        int          exp_passes;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int cnt;
        cnt = 0;
        while (!bus.InReady && cnt < 40) begin
            @(negedge Clk);
            cnt++;
        end
        check({name, "_ready_timeout"}, 32'(bus.InReady), 32'd1);
    endtask

    task automatic take_result(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got result 0x%08h, expected none queued", name, bus.OutData);
        end else begin
            e = exp_q.pop_front();
            check(name, bus.OutData, e);
        end
        bus.OutReady = 1'b1;
        @(negedge Clk);
        bus.OutReady = 1'b0;
        check({name, "_valid_after_take"}, 32'(bus.OutValid), 32'd0);
        check({name, "_ready_after_take"}, 32'(bus.InReady), 32'd1);
    endtask

    // Drive one request at a negedge in IDLE, follow it pass by pass, then take the result.
    task automatic run_req(input string name, input logic [31:0] d, input logic [7:0] a,
                           input logic f, input logic [31:0] exp_d, input int exp_n);
        int lat;
        int rem;
        int step;
        bus.InValid   = 1'b1;
        bus.InData    = d;
        bus.InAmount  = a;
        bus.InShiftIn = f;
        wait_ready(name);
        exp_q.push_back(exp_d);
        @(posedge Clk);
        @(negedge Clk);
        bus.InValid   = 1'b0;
        bus.InData    = $urandom;
        bus.InAmount  = 8'($urandom_range(0, 255));
        bus.InShiftIn = ~f;
        lat = 0;
        rem = int'(a);
        while (!bus.OutValid && lat < 40) begin
            step = (rem > MAX_STEP) ? MAX_STEP : rem;
            check({name, "_shf_amount"}, 32'(bus.ShfAmount), 32'(step));
            check({name, "_shf_fill"}, 32'(bus.ShfShiftIn), 32'(f));
            check({name, "_busy_ready"}, 32'(bus.InReady), 32'd0);
            rem = rem - step;
            @(negedge Clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_n));
        check({name, "_pass_count"}, 32'(bus.PassCount), 32'(exp_n));
        check({name, "_done_ready"}, 32'(bus.InReady), 32'd0);
        take_result(name);
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0001, 8'd4,   1'b0, 32'h0000_0010, 1};
        vecs[1]  = '{32'h8000_0001, 8'd0,   1'b0, 32'h8000_0001, 1};
        vecs[2]  = '{32'h0000_0001, 8'd31,  1'b0, 32'h8000_0000, 1};
        vecs[3]  = '{32'h0000_0001, 8'd62,  1'b0, 32'h0000_0000, 2};
        vecs[4]  = '{32'h1234_5678, 8'd255, 1'b1, 32'hFFFF_FFFF, 9};
        vecs[5]  = '{32'h0000_FFFF, 8'd8,   1'b1, 32'h00FF_FFFF, 1};
        vecs[6]  = '{32'hDEAD_BEEF, 8'd32,  1'b0, 32'h0000_0000, 2};
        vecs[7]  = '{32'h0000_000F, 8'd33,  1'b1, 32'hFFFF_FFFF, 2};
        vecs[8]  = '{32'hA5A5_A5A5, 8'd16,  1'b0, 32'hA5A5_0000, 1};
        vecs[9]  = '{32'h0000_0001, 8'd30,  1'b1, 32'h7FFF_FFFF, 1};
        vecs[10] = '{32'h1234_5678, 8'd4,   1'b1, 32'h2345_678F, 1};
        vecs[11] = '{32'h1234_5678, 8'd93,  1'b0, 32'h0000_0000, 3};

        ResetN        = 1'b0;
        bus.InValid   = 1'b0;
        bus.InData    = 32'h0;
        bus.InAmount  = 8'd0;
        bus.InShiftIn = 1'b0;
        bus.OutReady  = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("rst_in_ready",  32'(bus.InReady),    32'd1);
        check("rst_out_valid", 32'(bus.OutValid),   32'd0);
        check("rst_out_data",  bus.OutData,         32'd0);
        check("rst_shf_in",    bus.ShfIn,           32'd0);
        check("rst_shf_amt",   32'(bus.ShfAmount),  32'd0);
        check("rst_shf_fill",  32'(bus.ShfShiftIn), 32'd0);
        check("rst_pass_cnt",  32'(bus.PassCount),  32'd0);
        check("rst_state",     32'(dbg_state),      32'(IDLE));
        ResetN = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 12; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].data, vecs[i].amt, vecs[i].fill,
                    vecs[i].exp_data, vecs[i].exp_passes);
        end

        // Result held under back-pressure, then take and accept on the same edge.
        bus.InValid   = 1'b1;
        bus.InData    = 32'h0000_FFFF;
        bus.InAmount  = 8'd8;
        bus.InShiftIn = 1'b1;
        wait_ready("hold_a");
        exp_q.push_back(32'h00FF_FFFF);
        @(posedge Clk);
        @(negedge Clk);
        bus.InData    = 32'h0000_0001;
        bus.InAmount  = 8'd4;
        bus.InShiftIn = 1'b0;
        @(negedge Clk);
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", 32'(bus.OutValid), 32'd1);
            check("hold_data",  bus.OutData,       32'h00FF_FFFF);
            check("hold_ready", 32'(bus.InReady),  32'd0);
            @(negedge Clk);
        end
        check("b2b_first", bus.OutData, exp_q.pop_front());
        exp_q.push_back(32'h0000_0010);
        bus.OutReady = 1'b1;
        @(negedge Clk);
        bus.OutReady = 1'b0;
        bus.InValid  = 1'b0;
        check("b2b_valid_low", 32'(bus.OutValid),  32'd0);
        check("b2b_state",     32'(dbg_state),     32'(SHIFT));
        check("b2b_pass_clr",  32'(bus.PassCount), 32'd0);
        check("b2b_shf_in",    bus.ShfIn,          32'h0000_0001);
        @(negedge Clk);
        check("b2b_second_valid", 32'(bus.OutValid),  32'd1);
        check("b2b_second_pass",  32'(bus.PassCount), 32'd1);
        take_result("b2b_second");

        // Asynchronous reset during the third pass of an amount-100 request.
        bus.InValid   = 1'b1;
        bus.InData    = 32'h0000_0001;
        bus.InAmount  = 8'd100;
        bus.InShiftIn = 1'b1;
        wait_ready("abort");
        @(posedge Clk);
        @(negedge Clk);
        bus.InValid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("abort_pass_before", 32'(bus.PassCount), 32'd2);
        check("abort_amt_before",  32'(bus.ShfAmount), 32'd31);
        #2 ResetN = 1'b0;
        #1;
        check("abort_in_ready",  32'(bus.InReady),    32'd1);
        check("abort_out_valid", 32'(bus.OutValid),   32'd0);
        check("abort_out_data",  bus.OutData,         32'd0);
        check("abort_shf_in",    bus.ShfIn,           32'd0);
        check("abort_shf_amt",   32'(bus.ShfAmount),  32'd0);
        check("abort_shf_fill",  32'(bus.ShfShiftIn), 32'd0);
        check("abort_pass_cnt",  32'(bus.PassCount),  32'd0);
        check("abort_state",     32'(dbg_state),      32'(IDLE));
        @(negedge Clk);
        @(negedge Clk);
        check("abort_no_valid", 32'(bus.OutValid), 32'd0);
        ResetN = 1'b1;
        @(negedge Clk);
        check("abort_idle_valid", 32'(bus.OutValid), 32'd0);
        run_req("after_abort", vecs[4].data, vecs[4].amt, vecs[4].fill,
                vecs[4].exp_data, vecs[4].exp_passes);
        run_req("after_abort2", vecs[10].data, vecs[10].amt, vecs[10].fill,
                vecs[10].exp_data, vecs[10].exp_passes);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
